// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the synchronous FIFO domain and its
// write-side arbiter.
package sync_fifo_pkg;

   localparam int unsigned BUS_WIDTH   = 8;
   localparam int unsigned NUM_REQ_DEF = 4;
   localparam int unsigned LEN_W_DEF   = 4;

   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: one-hot select of the first set req bit at or
// above rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
   import sync_fifo_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic               valid
);

   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ
// producers, gated on fifo_full so no write reaches a full FIFO.
module fifo_wr_arbiter
   import sync_fifo_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned LEN_W   = LEN_W_DEF
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*LEN_W-1:0]     req_len,
   input  logic [NUM_REQ-1:0]           data_valid,
   input  logic [NUM_REQ*BUS_WIDTH-1:0] data_in,
   input  logic                         fifo_full,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         fifo_wr_en,
   output logic [BUS_WIDTH-1:0]         fifo_bus_in,
   output logic                         busy,
   output logic                         burst_done
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e         state, state_d;
   logic [NUM_REQ-1:0] gnt_d, pick;
   logic               pick_valid;
   logic [PTR_W-1:0]   pick_idx, gnt_idx, gnt_idx_d, rr_ptr, rr_ptr_d;
   logic [LEN_W-1:0]   beat_cnt, beat_cnt_d;
   logic               burst_done_d, accept;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .pick   (pick),
      .valid  (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (pick[k]) pick_idx = PTR_W'(k);
      end
   end

   // Owner index is registered alongside gnt so the data mux needs no encoder.
   assign accept      = (state == ARB_BURST) && data_valid[gnt_idx] && !fifo_full;
   assign fifo_wr_en  = accept;
   assign ack         = accept ? gnt : '0;
   assign fifo_bus_in = accept ? data_in[gnt_idx*BUS_WIDTH +: BUS_WIDTH] : '0;
   assign busy        = (state == ARB_BURST);

   always_comb begin
      state_d      = state;
      gnt_d        = gnt;
      gnt_idx_d    = gnt_idx;
      beat_cnt_d   = beat_cnt;
      rr_ptr_d     = rr_ptr;
      burst_done_d = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               gnt_d      = pick;
               gnt_idx_d  = pick_idx;
               beat_cnt_d = req_len[pick_idx*LEN_W +: LEN_W];
               rr_ptr_d   = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
               state_d    = ARB_BURST;
            end
         end
         ARB_BURST: begin
            if (accept) begin
               if (beat_cnt != '0) begin
                  beat_cnt_d = beat_cnt - 1'b1;
               end else begin
                  gnt_d        = '0;
                  state_d      = ARB_IDLE;
                  burst_done_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         gnt        <= '0;
         gnt_idx    <= '0;
         beat_cnt   <= '0;
         rr_ptr     <= '0;
         burst_done <= 1'b0;
      end else begin
         state      <= state_d;
         gnt        <= gnt_d;
         gnt_idx    <= gnt_idx_d;
         beat_cnt   <= beat_cnt_d;
         rr_ptr     <= rr_ptr_d;
         burst_done <= burst_done_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run against a burst-level reference model.
module tb_fifo_wr_arbiter;
   import sync_fifo_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned LW = 4;
   localparam int unsigned BW = BUS_WIDTH;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req, data_valid, gnt, ack;
   logic [N*LW-1:0]   req_len;
   logic [N*BW-1:0]   data_in;
   logic              fifo_full, fifo_wr_en, busy, burst_done;
   logic [BW-1:0]     fifo_bus_in;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ (N),
      .LEN_W   (LW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_len     (req_len),
      .data_valid  (data_valid),
      .data_in     (data_in),
      .fifo_full   (fifo_full),
      .gnt         (gnt),
      .ack         (ack),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_bus_in (fifo_bus_in),
      .busy        (busy),
      .burst_done  (burst_done)
   );

   task automatic set_len(input int i, input int v);
      req_len[i*LW +: LW] = LW'(v);
   endtask

   task automatic set_data(input int i, input int v);
      data_in[i*BW +: BW] = BW'(v);
   endtask

   function automatic logic [BW-1:0] dat(input int i);
      return data_in[i*BW +: BW];
   endfunction

   function automatic int get_len(input int i);
      return int'(req_len[i*LW +: LW]);
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst        = 1'b1;
      req        = '0;
      data_valid = '0;
      req_len    = '0;
      data_in    = '0;
      fifo_full  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      req        = '1;
      data_valid = '1;
      @(posedge clk);
      #1;
      checks++;
      if ({gnt, ack, busy, burst_done, fifo_wr_en} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b ack=%b busy=%b done=%b wr_en=%b, expected all zero",
                  gnt, ack, busy, burst_done, fifo_wr_en);
      end
      checks++;
      if (fifo_bus_in !== '0) begin
         errors++;
         $display("FAIL reset_bus: got %h expected 00", fifo_bus_in);
      end
      req        = '0;
      data_valid = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_burst();
      logic [BW-1:0] wr_q[$];
      logic [N-1:0]  gnt_log[7];
      logic          done_log[7];
      logic          prev_ack;
      apply_reset();
      prev_ack = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req[2] = 1'b1; set_len(2, 3); data_valid[2] = 1'b1; set_data(2, 'hA0);
         end
         if (gnt[2]) req[2] = 1'b0;
         if (prev_ack) set_data(2, int'(dat(2)) + 1);
         @(negedge clk);
         gnt_log[c]  = gnt;
         done_log[c] = burst_done;
         prev_ack    = ack[2];
         if (fifo_wr_en) wr_q.push_back(fifo_bus_in);
      end
      checks++;
      if (gnt_log[0] !== 4'b0000) begin errors++; $display("FAIL single_gnt_c0: got %b expected 0000", gnt_log[0]); end
      checks++;
      if (gnt_log[1] !== 4'b0100) begin errors++; $display("FAIL single_gnt_c1: got %b expected 0100", gnt_log[1]); end
      checks++;
      if (gnt_log[4] !== 4'b0100) begin errors++; $display("FAIL single_gnt_c4: got %b expected 0100", gnt_log[4]); end
      checks++;
      if (gnt_log[5] !== 4'b0000 || done_log[5] !== 1'b1) begin
         errors++; $display("FAIL single_done: gnt=%b done=%b expected gnt=0000 done=1", gnt_log[5], done_log[5]);
      end
      checks++;
      if (done_log[4] !== 1'b0 || done_log[6] !== 1'b0) begin
         errors++; $display("FAIL single_done_pulse: c4=%b c6=%b expected 0 0", done_log[4], done_log[6]);
      end
      checks++;
      if (wr_q.size() != 4) begin errors++; $display("FAIL single_count: got %0d writes expected 4", wr_q.size()); end
      for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== BW'('hA0 + k)) begin
            errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, wr_q[k], BW'('hA0 + k));
         end
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_gnt;
      int           k;
      apply_reset();
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req = '1; data_valid = '1; req_len = '0;
            for (int i = 0; i < N; i++) set_data(i, 'h10 + i);
         end
         @(negedge clk);
         k       = ((c - 1) / 2) % N;
         exp_gnt = (c % 2 == 1) ? (N'(1) << k) : '0;
         checks++;
         if (gnt !== exp_gnt) begin
            errors++; $display("FAIL rr_gnt_c%0d: got %b expected %b", c, gnt, exp_gnt);
         end
         if (c % 2 == 1) begin
            checks++;
            if (fifo_wr_en !== 1'b1 || fifo_bus_in !== BW'('h10 + k)) begin
               errors++; $display("FAIL rr_write_c%0d: wr_en=%b bus=%h expected 1 %h", c, fifo_wr_en, fifo_bus_in, BW'('h10 + k));
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [BW-1:0] wr_q[$];
      logic          prev_ack;
      logic          done_c10;
      apply_reset();
      prev_ack = 1'b0;
      done_c10 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req[1] = 1'b1; set_len(1, 5); data_valid[1] = 1'b1; set_data(1, 'hB0);
         end
         if (gnt[1]) req[1] = 1'b0;
         if (prev_ack) set_data(1, int'(dat(1)) + 1);
         fifo_full = (c >= 3 && c <= 5);
         @(negedge clk);
         prev_ack = ack[1];
         if (fifo_wr_en) wr_q.push_back(fifo_bus_in);
         if (c == 10) done_c10 = burst_done;
         if (c >= 3 && c <= 5) begin
            checks++;
            if (fifo_wr_en !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0010) begin
               errors++; $display("FAIL bp_stall_c%0d: wr_en=%b ack=%b gnt=%b expected 0 0000 0010", c, fifo_wr_en, ack, gnt);
            end
         end
      end
      checks++;
      if (wr_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d writes expected 6", wr_q.size()); end
      for (int k = 0; k < 6 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== BW'('hB0 + k)) begin
            errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, wr_q[k], BW'('hB0 + k));
         end
      end
      checks++;
      if (done_c10 !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done_c10); end
   endtask

   task automatic test_producer_stall();
      logic [BW-1:0] wr_q[$];
      logic          prev_ack;
      apply_reset();
      prev_ack = 1'b0;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req[0] = 1'b1; set_len(0, 3); set_data(0, 'hC0);
         end
         if (gnt[0]) req[0] = 1'b0;
         if (prev_ack) set_data(0, int'(dat(0)) + 1);
         data_valid[0] = !(c == 2 || c == 3);
         @(negedge clk);
         prev_ack = ack[0];
         if (fifo_wr_en) wr_q.push_back(fifo_bus_in);
         if (c == 2 || c == 3) begin
            checks++;
            if (fifo_wr_en !== 1'b0 || gnt !== 4'b0001) begin
               errors++; $display("FAIL stall_c%0d: wr_en=%b gnt=%b expected 0 0001", c, fifo_wr_en, gnt);
            end
         end
         if (c == 7) begin
            checks++;
            if (gnt !== 4'b0000 || burst_done !== 1'b1) begin
               errors++; $display("FAIL stall_end: gnt=%b done=%b expected 0000 1", gnt, burst_done);
            end
         end
      end
      checks++;
      if (wr_q.size() != 4) begin errors++; $display("FAIL stall_count: got %0d writes expected 4", wr_q.size()); end
      for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== BW'('hC0 + k)) begin
            errors++; $display("FAIL stall_data[%0d]: got %h expected %h", k, wr_q[k], BW'('hC0 + k));
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic prev_ack;
      int   writes;
      apply_reset();
      prev_ack = 1'b0;
      writes   = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req[1] = 1'b1; set_len(1, 3); data_valid[1] = 1'b1; set_data(1, 'hD0);
         end
         if (gnt[1]) req[1] = 1'b0;
         if (prev_ack) set_data(1, int'(dat(1)) + 1);
         @(negedge clk);
         prev_ack = ack[1];
         if (fifo_wr_en) writes++;
      end
      checks++;
      if (writes != 2) begin errors++; $display("FAIL rst_mid_prewrites: got %0d expected 2", writes); end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt, busy, fifo_wr_en, ack, burst_done} !== '0) begin
         errors++; $display("FAIL rst_mid_outputs: gnt=%b busy=%b wr_en=%b ack=%b done=%b expected all zero",
                             gnt, busy, fifo_wr_en, ack, burst_done);
      end
      req = 4'b1001; data_valid = 4'b1011; req_len = '0;
      set_data(0, 'h01); set_data(3, 'h03);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001 || fifo_bus_in !== 8'h01) begin
         errors++; $display("FAIL rst_mid_regrant: gnt=%b bus=%h expected 0001 01", gnt, fifo_bus_in);
      end
      req[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (gnt !== 4'b1000) begin errors++; $display("FAIL rst_mid_next: gnt=%b expected 1000", gnt); end
   endtask

   task automatic test_max_length_wrap();
      logic [BW-1:0] wr_q[$];
      logic          prev_ack;
      int            gnt_cycles;
      apply_reset();
      prev_ack   = 1'b0;
      gnt_cycles = 0;
      for (int c = 0; c < 19; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            req[3] = 1'b1; set_len(3, 15); data_valid[3] = 1'b1; set_data(3, 'h40);
         end
         if (gnt[3]) req[3] = 1'b0;
         if (prev_ack) set_data(3, int'(dat(3)) + 1);
         if (c == 17) begin
            req = 4'b1001; data_valid[0] = 1'b1; set_data(0, 'h77);
         end
         @(negedge clk);
         prev_ack = ack[3];
         if (gnt === 4'b1000) gnt_cycles++;
         if (fifo_wr_en && gnt === 4'b1000) wr_q.push_back(fifo_bus_in);
         if (c == 17) begin
            checks++;
            if (burst_done !== 1'b1 || gnt !== 4'b0000) begin
               errors++; $display("FAIL max_done: done=%b gnt=%b expected 1 0000", burst_done, gnt);
            end
         end
         if (c == 18) begin
            checks++;
            if (gnt !== 4'b0001) begin errors++; $display("FAIL max_wrap: gnt=%b expected 0001", gnt); end
         end
      end
      checks++;
      if (gnt_cycles != 16) begin errors++; $display("FAIL max_gnt_len: got %0d cycles expected 16", gnt_cycles); end
      checks++;
      if (wr_q.size() != 16) begin errors++; $display("FAIL max_count: got %0d writes expected 16", wr_q.size()); end
      for (int k = 0; k < 16 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== BW'('h40 + k)) begin
            errors++; $display("FAIL max_data[%0d]: got %h expected %h", k, wr_q[k], BW'('h40 + k));
         end
      end
   endtask

   task automatic test_random();
      bit            m_busy, m_done, acc;
      int            m_owner, m_rem, m_ptr, w;
      logic [N-1:0]  e_gnt, e_ack;
      logic [BW-1:0] e_bus;
      apply_reset();
      m_busy = 1'b0; m_done = 1'b0; m_owner = 0; m_rem = 0; m_ptr = 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (gnt[i]) req[i] = 1'b0;
            else if (!req[i]) req[i] = ($urandom_range(3) == 0);
            set_len(i, int'($urandom_range(3)));
            data_valid[i] = ($urandom_range(3) != 0);
            set_data(i, int'($urandom_range(255)));
         end
         fifo_full = ($urandom_range(4) == 0);
         @(negedge clk);
         e_gnt = m_busy ? (N'(1) << m_owner) : '0;
         acc   = m_busy && data_valid[m_owner] && !fifo_full;
         e_ack = acc ? e_gnt : '0;
         e_bus = acc ? dat(m_owner) : '0;
         checks++;
         if ({gnt, ack, fifo_wr_en, busy, burst_done, fifo_bus_in} !==
             {e_gnt, e_ack, acc, m_busy, m_done, e_bus}) begin
            errors++;
            $display("FAIL random_c%0d: gnt=%b ack=%b wr=%b busy=%b done=%b bus=%h expected %b %b %b %b %b %h",
                     c, gnt, ack, fifo_wr_en, busy, burst_done, fifo_bus_in,
                     e_gnt, e_ack, acc, m_busy, m_done, e_bus);
         end
         m_done = 1'b0;
         if (!m_busy) begin
            if (req != '0) begin
               w = -1;
               for (int k = 0; k < N; k++) begin
                  if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
               end
               m_busy  = 1'b1;
               m_owner = w;
               m_rem   = get_len(w) + 1;
               m_ptr   = (w + 1) % N;
            end
         end else if (acc) begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
      end
   endtask

   initial begin
      req        = '0;
      req_len    = '0;
      data_valid = '0;
      data_in    = '0;
      fifo_full  = 1'b0;
      test_reset();
      test_single_burst();
      test_round_robin();
      test_back_pressure();
      test_producer_stall();
      test_reset_mid_burst();
      test_max_length_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
